uart_frame_echo: RTL and testbench

UART_FRAME_ECHO -- requirements
Module: uart_frame_echo

---
 rtl/uart_pkg.sv | 29 ++
 rtl/frame_buf.sv | 23 ++
 rtl/uart_rx.sv | 87 ++++++++
 rtl/uart_tx.sv | 99 +++++++++
 rtl/uart_frame_echo.sv | 153 +++++++++++++++
 tb/tb_uart_frame_echo.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame echo: FSM states, echo modes, mode decode.
// Pure declarations: no latency or flow control of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_LOAD,
    ST_TX_WAIT,
    ST_DONE
  } echo_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  localparam logic [1:0] MODE_FWD  = 2'd0;
  localparam logic [1:0] MODE_REV  = 2'd1;
  localparam logic [1:0] MODE_CSUM = 2'd2;

  // The unused encoding 3 behaves as a plain forward echo.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_FWD : m;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Frame byte store: one synchronous write port, one combinational read port.
// Write lands on the next edge; no backpressure, contents survive reset.
module frame_buf #(
  parameter int NBYTES_MAX = 16,
  parameter int AW         = $clog2(NBYTES_MAX)
) (
  input  logic          iClk,
  input  logic          iWe,
  input  logic [AW-1:0] iWaddr,
  input  logic [7:0]    iWdata,
  input  logic [AW-1:0] iRaddr,
  output logic [7:0]    oRdata
);

  logic [7:0] mem_q [NBYTES_MAX];

  always_ff @(posedge iClk) begin
    if (iWe) mem_q[iWaddr] <= iWdata;
  end

  assign oRdata = mem_q[iRaddr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oDone pulses one cycle, mid stop bit, with oByte valid.
// Latency ~9.5 bit times from start edge; no backpressure, bytes are not held.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic       oDone,
  output logic [7:0] oByte
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  uart_state_e   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          done_q, done_d;
  logic          s1_q, s2_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    case (st_q)
      U_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!s2_q) st_d = U_START;
      end
      U_START: begin
        // Re-check the line half a bit in to reject glitches.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          st_d  = s2_q ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = U_STOP;
        end
      end
      default: begin
        if (cnt_q == FULL) begin
          st_d   = U_IDLE;
          done_d = s2_q;
        end
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      st_q   <= U_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      done_q <= done_d;
      s1_q   <= iRx;
      s2_q   <= s1_q;
    end
  end

  assign oDone = done_q;
  assign oByte = sh_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: iStart (while idle) launches iByte; oDone pulses after stop.
// Line goes low the edge after iStart; iStart is ignored while oBusy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iByte,
  output logic       oTx,
  output logic       oBusy,
  output logic       oDone
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  uart_state_e   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    tx_d   = tx_q;
    done_d = 1'b0;
    case (st_q)
      U_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (iStart) begin
          sh_d = iByte;
          tx_d = 1'b0;
          st_d = U_START;
        end
      end
      U_START: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          bit_d = '0;
          tx_d  = sh_q[0];
          sh_d  = {1'b0, sh_q[7:1]};
          st_d  = U_DATA;
        end
      end
      U_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
            st_d = U_STOP;
          end else begin
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        if (cnt_q == FULL) begin
          st_d   = U_IDLE;
          done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      st_q   <= U_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      tx_q   <= tx_d;
      done_q <= done_d;
    end
  end

  assign oTx   = tx_q;
  assign oBusy = (st_q != U_IDLE);
  assign oDone = done_q;

endmodule

// File: rtl/uart_frame_echo.sv
// Collects a UART frame (terminator, full buffer or idle timeout) and echoes it per mode.
// Bytes arriving while echoing are not buffered: they are discarded and flagged on oDrop.
module uart_frame_echo
  import uart_pkg::*;
#(
  parameter int         NBYTES_MAX    = 16,
  parameter int         CLK_FREQ      = 125_000_000,
  parameter int         BAUD_RATE     = 115_200,
  parameter logic [7:0] TERM_BYTE     = 8'h0D,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iRx,
  input  logic [1:0]                  iMode,
  output logic                        oTx,
  output logic                        oBusy,
  output logic [$clog2(NBYTES_MAX):0] oLen,
  output logic                        oDrop
);

  localparam int AW        = $clog2(NBYTES_MAX);
  localparam int CW        = AW + 1;
  localparam int TMO_LIMIT = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [CW-1:0] NB      = CW'(NBYTES_MAX);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_LIMIT - 1);

  logic       wRxDone, wTxBusy, wTxDone;
  logic [7:0] wRxByte, buf_rdata;

  echo_state_e   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, len_q, len_d, total;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    csum_q, csum_d, tx_byte_q, tx_byte_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d, tx_start_q, tx_start_d;
  logic          buf_we, close;
  logic [AW-1:0] buf_raddr;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .iClk (iClk), .iRst (iRst), .iRx (iRx), .oDone (wRxDone), .oByte (wRxByte)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .iClk (iClk), .iRst (iRst), .iStart (tx_start_q), .iByte (tx_byte_q),
    .oTx (oTx), .oBusy (wTxBusy), .oDone (wTxDone)
  );

  frame_buf #(.NBYTES_MAX(NBYTES_MAX), .AW(AW)) u_buf (
    .iClk (iClk), .iWe (buf_we), .iWaddr (AW'(cnt_q)), .iWdata (wRxByte),
    .iRaddr (buf_raddr), .oRdata (buf_rdata)
  );

  // The checksum byte, when present, sits logically at index == count.
  assign total     = cnt_q + ((mode_q == MODE_CSUM) ? CW'(1) : CW'(0));
  assign buf_raddr = (mode_q == MODE_REV) ? AW'(cnt_q - idx_q - CW'(1)) : AW'(idx_q);

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    csum_d     = csum_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    buf_we     = 1'b0;
    close      = 1'b0;
    case (st_q)
      ST_IDLE: st_d = ST_RX;
      ST_RX: begin
        // A byte landing on the timeout cycle wins over the timeout.
        if (wRxDone) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          csum_d = csum_q ^ wRxByte;
          tmo_d  = '0;
          close  = (wRxByte == TERM_BYTE) || (cnt_d == NB);
        end else if (cnt_q != '0) begin
          if (tmo_q == TMO_END) close = 1'b1;
          else                  tmo_d = tmo_q + TW'(1);
        end
        if (close) begin
          mode_d = norm_mode(iMode);
          len_d  = cnt_d;
          idx_d  = '0;
          tmo_d  = '0;
          busy_d = 1'b1;
          st_d   = ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!wTxBusy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = (idx_q == cnt_q) ? csum_q : buf_rdata;
          st_d       = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (wTxDone) begin
          if (idx_q + CW'(1) == total) begin
            busy_d = 1'b0;
            st_d   = ST_DONE;
          end else begin
            idx_d = idx_q + CW'(1);
            st_d  = ST_TX_LOAD;
          end
        end
      end
      default: begin
        cnt_d  = '0;
        idx_d  = '0;
        csum_d = '0;
        tmo_d  = '0;
        st_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      csum_q     <= '0;
      mode_q     <= MODE_FWD;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      csum_q     <= csum_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign oBusy = busy_q;
  assign oLen  = len_q;
  assign oDrop = wRxDone && (st_q != ST_RX);

endmodule

// File: tb/tb_uart_frame_echo.sv
// Randomised scoreboard bench for uart_frame_echo: serial stimulus in, serial decode out.
module tb_uart_frame_echo;

  localparam int NB  = 8;
  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;

  logic       iClk = 1'b0;
  logic       iRst, iRx, oTx, oBusy, oDrop;
  logic [1:0] iMode;
  logic [3:0] oLen;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rst_epoch = 0;
  int         drop_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];

  uart_frame_echo #(
    .NBYTES_MAX(NB), .CLK_FREQ(CF), .BAUD_RATE(BR), .TERM_BYTE(8'h0D), .TIMEOUT_BYTES(4)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iRx(iRx), .iMode(iMode),
    .oTx(oTx), .oBusy(oBusy), .oLen(oLen), .oDrop(oDrop)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oDrop) drop_cnt++;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Serial decoder: every byte seen on oTx is scored against the expected queue.
  initial begin : monitor
    logic [7:0] b;
    int         ep;
    logic       busy_s;
    forever begin
      @(negedge oTx);
      if (mon_en) begin
        ep = rst_epoch;
        repeat (CPB / 2) @(posedge iClk);
        #1 busy_s = oBusy;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge iClk);
          #1 b[i] = oTx;
        end
        repeat (CPB) @(posedge iClk);
        #1;
        if (ep == rst_epoch) begin
          check("tx_busy_during_byte", int'(busy_s), 1);
          check("tx_stop_bit", int'(oTx), 1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got 0x%0h, expected no byte", b);
          end else begin
            check("tx_byte", int'(b), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    iRx = 1'b0;
    repeat (CPB) @(negedge iClk);
    for (int i = 0; i < 8; i++) begin
      iRx = b[i];
      repeat (CPB) @(negedge iClk);
    end
    iRx = 1'b1;
    repeat (CPB) @(negedge iClk);
  endtask

  // Reference: echo is the frame as received, reversed for mode 1, XOR byte appended for mode 2.
  task automatic model_frame(input logic [1:0] m);
    logic [7:0] x;
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    if (m == 2'd1) for (int i = frame_q.size() - 1; i >= 0; i--) exp_q.push_back(frame_q[i]);
    else           foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    if (m == 2'd2) exp_q.push_back(x);
  endtask

  task automatic start_frame(input logic [1:0] m);
    iMode = m;
    model_frame(m);
    foreach (frame_q[i]) send_byte(frame_q[i]);
  endtask

  task automatic finish_frame(input int len);
    int t;
    t = 0;
    while (!oBusy && t < 2000) begin @(negedge iClk); t++; end
    check("busy_at_close", int'(oBusy), 1);
    iMode = 2'($urandom_range(0, 3));
    t = 0;
    while (oBusy && t < 3000) begin @(negedge iClk); t++; end
    check("busy_after_tx", int'(oBusy), 0);
    repeat (20) @(negedge iClk);
    check("frame_len", int'(oLen), len);
  endtask

  initial begin
    int         d0, len, kind;
    logic [1:0] m;
    logic [7:0] b;
    iRst = 1'b1; iRx = 1'b1; iMode = 2'd0;
    repeat (3) @(negedge iClk);
    check("rst_tx", int'(oTx), 1);
    check("rst_busy", int'(oBusy), 0);
    check("rst_len", int'(oLen), 0);
    check("rst_drop", int'(oDrop), 0);
    iRst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge iClk);

    frame_q = '{8'h41, 8'h42, 8'h0D};
    start_frame(2'd0); finish_frame(3);

    frame_q = '{8'h31, 8'h32, 8'h33};
    start_frame(2'd1); finish_frame(3);

    frame_q = '{8'h01, 8'h02, 8'h04, 8'h0D};
    start_frame(2'd2); finish_frame(4);

    // Full buffer close, then a ninth byte while echoing must be dropped.
    frame_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    start_frame(2'd0);
    d0 = drop_cnt;
    send_byte(8'h99);
    finish_frame(8);
    check("drop_ninth_byte", drop_cnt - d0, 1);

    // Terminator as the last slot closes once.
    frame_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h0D};
    d0 = drop_cnt;
    start_frame(2'd0); finish_frame(8);
    check("no_drop_term_full", drop_cnt - d0, 0);

    // Reset in the middle of the second echoed byte.
    frame_q = '{8'h11, 8'h22, 8'h0D};
    start_frame(2'd0);
    repeat (150) @(negedge iClk);
    rst_epoch++;
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    check("midtx_rst_tx", int'(oTx), 1);
    check("midtx_rst_busy", int'(oBusy), 0);
    check("midtx_rst_len", int'(oLen), 0);
    iRst = 1'b0;
    check("midtx_first_byte_sent", exp_q.size(), 2);
    exp_q.delete();
    repeat (150) @(negedge iClk);
    frame_q = '{8'h55, 8'h0D};
    start_frame(2'd0); finish_frame(2);

    for (int f = 0; f < 8; f++) begin
      m    = 2'($urandom_range(0, 3));
      len  = $urandom_range(1, NB);
      kind = $urandom_range(0, 1);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D) b = 8'h0E;
        frame_q.push_back(b);
      end
      if (kind == 0) frame_q[len - 1] = 8'h0D;
      start_frame(m);
      finish_frame(len);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
